// File: rtl/fifo_flow.sv
// Synchronous valid/ready FIFO with arbitrary depth, show-ahead or registered read,
// fill level, almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_flow #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LEVEL   = LW'(AE_THRESH);

  // Handshake: a write transfers on a clock edge where wr_valid && wr_ready; a read
  // transfers where rd_ready && level != 0. clear suppresses both and all flag updates.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  wr_block;
  logic                  rd_block;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Ready is derived from the registered level only, so rd_ready never reaches wr_ready.
  assign full     = (level_q == FULL_LEVEL);
  assign empty    = (level_q == '0);
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full && !clear;
  assign wr_block = wr_valid && full && !clear;
  assign rd_fire  = rd_ready && !empty && !clear;
  assign rd_block = (FWFT == 0) && rd_ready && empty && !clear;

  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LEVEL);
  assign almost_empty = (level_q <= AE_LEVEL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (wr_block) overflow_q  <= 1'b1;
      if (rd_block) underflow_q <= 1'b1;
    end
  end

  // Storage carries no reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_show_ahead
      assign rd_valid = !empty;
      assign rd_data  = empty ? '0 : mem[rd_ptr];
    end else begin : g_registered
      logic                  rd_valid_q;
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else if (clear) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_fire;
          if (rd_fire) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_valid = rd_valid_q;
      assign rd_data  = rd_data_q;
    end
  endgenerate

endmodule
